// File: rtl/io_map_pkg.sv
// io_map_pkg: address map, FSM state encoding and small helpers shared by the
// switch/sum bus initiator and its interface.
package io_map_pkg;

  localparam int IO_DATA_W = 32;
  localparam int IO_ADDR_W = 4;

  // Responder address map. Only 0..4 may ever be written: the responder
  // treats a write to any other address as "clear all outputs".
  localparam logic [IO_ADDR_W-1:0] IO_HEX01  = 4'd0;
  localparam logic [IO_ADDR_W-1:0] IO_HEX23  = 4'd1;
  localparam logic [IO_ADDR_W-1:0] IO_HEX45  = 4'd2;
  localparam logic [IO_ADDR_W-1:0] IO_LED_LO = 4'd3;
  localparam logic [IO_ADDR_W-1:0] IO_LED_HI = 4'd4;
  localparam logic [IO_ADDR_W-1:0] IO_SW_LO  = 4'd5;
  localparam logic [IO_ADDR_W-1:0] IO_SW_HI  = 4'd6;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RD_A,
    ST_RD_B,
    ST_CAP_B,
    ST_CMP,
    ST_WR_H0,
    ST_WR_H1,
    ST_WR_H2,
    ST_WR_L0,
    ST_WR_L1,
    ST_DONE,
    ST_WAIT
  } io_state_e;

  // Which captured value a bus cycle carries on io_wdata.
  typedef enum logic [1:0] {
    SRC_ZERO,
    SRC_A,
    SRC_B,
    SRC_SUM
  } io_src_e;

  typedef struct packed {
    logic [IO_ADDR_W-1:0] addr;
    logic                 we;
    io_src_e              src;
  } io_cmd_t;

  // Bus command presented while the FSM sits in state s.
  function automatic io_cmd_t io_cmd_for(io_state_e s);
    io_cmd_t c;
    c.addr = IO_HEX01;
    c.we   = 1'b0;
    c.src  = SRC_ZERO;
    case (s)
      ST_RD_A:  c.addr = IO_SW_LO;
      ST_RD_B:  c.addr = IO_SW_HI;
      ST_WR_H0: begin c.addr = IO_HEX01;  c.we = 1'b1; c.src = SRC_A;   end
      ST_WR_H1: begin c.addr = IO_HEX23;  c.we = 1'b1; c.src = SRC_B;   end
      ST_WR_H2: begin c.addr = IO_HEX45;  c.we = 1'b1; c.src = SRC_SUM; end
      ST_WR_L0: begin c.addr = IO_LED_LO; c.we = 1'b1; c.src = SRC_A;   end
      ST_WR_L1: begin c.addr = IO_LED_HI; c.we = 1'b1; c.src = SRC_B;   end
      default:  ;
    endcase
    return c;
  endfunction

  // Zero-extended 5+5 bit add; 31+31 = 62 fits in 6 bits.
  function automatic logic [5:0] sum6(logic [4:0] a, logic [4:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

  function automatic logic is_busy(io_state_e s);
    return !(s == ST_IDLE || s == ST_WAIT);
  endfunction

endpackage

// File: rtl/io_sw_sum_master_if.sv
// io_sw_sum_master_if: 4-bit-address I/O port between the sweep initiator
// (master) and the LED/hex/switch responder (slave).
//
// Bus protocol: there is no valid/ready pair. The master owns every cycle:
// io_we=1 for exactly one cycle commits io_wdata to io_addr; io_we=0 with an
// address is a read, and the responder registers io_rdata on the edge that
// ends that cycle, so read data is valid in the following cycle.
interface io_sw_sum_master_if;
  import io_map_pkg::*;

  logic [IO_ADDR_W-1:0] io_addr;
  logic [IO_DATA_W-1:0] io_wdata;
  logic                 io_we;
  logic [IO_DATA_W-1:0] io_rdata;

  modport master (output io_addr, output io_wdata, output io_we, input io_rdata);
  modport slave  (input io_addr, input io_wdata, input io_we, output io_rdata);
endinterface

// File: rtl/io_poll_timer.sv
// io_poll_timer: down-counter that spaces switch sweeps. Loading arms it for
// POLL_PERIOD ticks; expire is high once the count has run down to zero.
module io_poll_timer #(
  parameter int POLL_PERIOD = 50000
) (
  input  logic clock,
  input  logic resetn,
  input  logic load,
  input  logic tick,
  output logic expire
);

  localparam int CNT_W = $clog2(POLL_PERIOD + 1);
  // Reload with PERIOD-1 so that the WAIT cycle that observes zero is the
  // POLL_PERIOD-th one.
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(POLL_PERIOD - 1);

  logic [CNT_W-1:0] count;

  // Load on entry to WAIT, count down one per WAIT cycle, hold at zero.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      count <= '0;
    end else if (load) begin
      count <= RELOAD;
    end else if (tick && count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign expire = (count == '0);

endmodule

// File: rtl/io_sw_sum_master.sv
// io_sw_sum_master: reads both switch groups, forms A, B and A+B, and writes
// them to the hex pairs and LED groups. Write-back is skipped when the
// switches match the last written values. All bus outputs are registers.
module io_sw_sum_master
  import io_map_pkg::*;
#(
  parameter int POLL_PERIOD = 50000
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                enable,
  io_sw_sum_master_if.master  bus,
  output logic                busy,
  output logic                sweep_done,
  output logic [5:0]          sum_out,
  output io_state_e           state_dbg
);

  io_state_e state;
  io_state_e next_state;
  io_cmd_t   next_cmd;

  logic [4:0] a_q;
  logic [4:0] b_q;
  logic [4:0] last_a;
  logic [4:0] last_b;
  logic       last_valid;
  logic       changed;

  logic       timer_load;
  logic       timer_tick;
  logic       timer_expire;

  logic [IO_DATA_W-1:0] wdata_next;

  // Only the low five switch bits carry an operand.
  logic unused_rdata_hi;
  assign unused_rdata_hi = ^bus.io_rdata[IO_DATA_W-1:5];

  assign changed   = !last_valid || (a_q != last_a) || (b_q != last_b);
  assign state_dbg = state;

  // Arm the timer on every entry to WAIT; count only while in WAIT.
  assign timer_load = (state == ST_CMP && !changed) || (state == ST_DONE);
  assign timer_tick = (state == ST_WAIT);

  io_poll_timer #(
    .POLL_PERIOD (POLL_PERIOD)
  ) u_timer (
    .clock  (clock),
    .resetn (resetn),
    .load   (timer_load),
    .tick   (timer_tick),
    .expire (timer_expire)
  );

  // Next-state decision. enable is only honoured in IDLE, DONE and WAIT, so
  // a write sequence once started always runs to DONE.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:  if (enable) next_state = ST_RD_A;
      ST_RD_A:  next_state = ST_RD_B;
      ST_RD_B:  next_state = ST_CAP_B;
      ST_CAP_B: next_state = ST_CMP;
      ST_CMP:   next_state = changed ? ST_WR_H0 : ST_WAIT;
      ST_WR_H0: next_state = ST_WR_H1;
      ST_WR_H1: next_state = ST_WR_H2;
      ST_WR_H2: next_state = ST_WR_L0;
      ST_WR_L0: next_state = ST_WR_L1;
      ST_WR_L1: next_state = ST_DONE;
      ST_DONE:  next_state = enable ? ST_WAIT : ST_IDLE;
      ST_WAIT: begin
        if (!enable) begin
          next_state = ST_IDLE;
        end else if (timer_expire) begin
          next_state = ST_RD_A;
        end
      end
      default:  next_state = ST_IDLE;
    endcase
  end

  assign next_cmd = io_cmd_for(next_state);

  // Write data for the upcoming cycle; bits above the operand stay zero.
  always_comb begin
    wdata_next = '0;
    case (next_cmd.src)
      SRC_A:   wdata_next[4:0] = a_q;
      SRC_B:   wdata_next[4:0] = b_q;
      SRC_SUM: wdata_next[5:0] = sum6(a_q, b_q);
      default: ;
    endcase
  end

  // State, operand capture and registered bus/status outputs. Outputs are
  // loaded from the next state so they line up with the state register.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state        <= ST_IDLE;
      a_q          <= '0;
      b_q          <= '0;
      last_a       <= '0;
      last_b       <= '0;
      last_valid   <= 1'b0;
      sum_out      <= '0;
      bus.io_addr  <= IO_HEX01;
      bus.io_we    <= 1'b0;
      bus.io_wdata <= '0;
      busy         <= 1'b0;
      sweep_done   <= 1'b0;
    end else begin
      state <= next_state;

      // Read data for the address shown in the previous cycle arrives now.
      if (state == ST_RD_B)  a_q <= bus.io_rdata[4:0];
      if (state == ST_CAP_B) b_q <= bus.io_rdata[4:0];

      bus.io_addr  <= next_cmd.addr;
      bus.io_we    <= next_cmd.we;
      bus.io_wdata <= wdata_next;
      busy         <= is_busy(next_state);
      sweep_done   <= (next_state == ST_DONE);

      if (next_state == ST_DONE) begin
        last_a     <= a_q;
        last_b     <= b_q;
        last_valid <= 1'b1;
        sum_out    <= sum6(a_q, b_q);
      end
    end
  end

endmodule

// File: tb/tb_io_sw_sum_master.sv
// tb_io_sw_sum_master: directed bench for the switch/sum bus initiator. A
// main instance (short poll period) runs the write/skip/enable/reset
// scenarios; a second instance with POLL_PERIOD=1 measures sweep spacing.
module tb_io_sw_sum_master;
  import io_map_pkg::*;

  localparam int P_MAIN = 3;
  localparam int P_FAST = 1;

  // ---------------- clock / reset ----------------
  logic clock   = 1'b0;
  logic resetn  = 1'b0;
  logic enable  = 1'b0;
  logic enable1 = 1'b0;
  logic [9:0] sw  = '0;
  logic [9:0] sw1 = 10'h0A5;

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // ---------------- DUTs ----------------
  logic       busy, sweep_done, busy1, sweep_done1;
  logic [5:0] sum_out, sum_out1;
  io_state_e  state_dbg, state_dbg1;

  io_sw_sum_master_if bus ();
  io_sw_sum_master_if bus1 ();

  io_sw_sum_master #(.POLL_PERIOD(P_MAIN)) u_dut (
    .clock      (clock),
    .resetn     (resetn),
    .enable     (enable),
    .bus        (bus),
    .busy       (busy),
    .sweep_done (sweep_done),
    .sum_out    (sum_out),
    .state_dbg  (state_dbg)
  );

  io_sw_sum_master #(.POLL_PERIOD(P_FAST)) u_dut_fast (
    .clock      (clock),
    .resetn     (resetn),
    .enable     (enable1),
    .bus        (bus1),
    .busy       (busy1),
    .sweep_done (sweep_done1),
    .sum_out    (sum_out1),
    .state_dbg  (state_dbg1)
  );

  // Responder models: read data registered one cycle after the address.
  always @(posedge clock) begin
    case (bus.io_addr)
      IO_SW_LO: bus.io_rdata <= {27'd0, sw[4:0]};
      IO_SW_HI: bus.io_rdata <= {27'd0, sw[9:5]};
      default:  bus.io_rdata <= '0;
    endcase
  end

  always @(posedge clock) begin
    case (bus1.io_addr)
      IO_SW_LO: bus1.io_rdata <= {27'd0, sw1[4:0]};
      IO_SW_HI: bus1.io_rdata <= {27'd0, sw1[9:5]};
      default:  bus1.io_rdata <= '0;
    endcase
  end

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;

  logic [9:0] exp_q[$];   // {addr, data[5:0]} expected writes
  logic [9:0] wr_q[$];    // {addr, data[5:0]} observed writes

  int rd5_cnt = 0, rd6_cnt = 0, done_cnt = 0;
  int last_rda = 0, period = 0, lat = 0;
  logic [31:0] last_h45 = '0;

  int  rda1_cnt = 0, last_rda1 = 0, period1 = 0, done1_cnt = 0;
  bit  toggle1 = 1'b1;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Main instance bus monitor.
  always @(negedge clock) begin
    if (bus.io_we) begin
      wr_q.push_back({bus.io_addr, bus.io_wdata[5:0]});
      check("wdata_hi_zero", {6'd0, bus.io_wdata[31:6]}, 32'd0);
      if (bus.io_addr == IO_HEX45) last_h45 = bus.io_wdata;
      if (bus.io_addr == IO_HEX01) lat = cyc - last_rda;
    end else if (bus.io_addr == IO_SW_LO) begin
      rd5_cnt++;
      period   = cyc - last_rda;
      last_rda = cyc;
    end else if (bus.io_addr == IO_SW_HI) begin
      rd6_cnt++;
    end
    if (sweep_done) done_cnt++;
  end

  // Fast instance monitor; optionally flips the switches at each sweep start
  // so every sweep sees a change.
  always @(negedge clock) begin
    if (bus1.io_we) begin
      check("fast_wdata_hi_zero", {6'd0, bus1.io_wdata[31:6]}, 32'd0);
    end else if (bus1.io_addr == IO_SW_LO) begin
      rda1_cnt++;
      period1   = cyc - last_rda1;
      last_rda1 = cyc;
      if (toggle1) sw1 = ~sw1;
    end
    if (sweep_done1) done1_cnt++;
  end

  // ---------------- driver tasks ----------------
  task automatic tick(int n);
    repeat (n) begin
      @(negedge clock);
      #1;
    end
  endtask

  task automatic exp_sweep(logic [5:0] a, logic [5:0] b, logic [5:0] s);
    exp_q.push_back({IO_HEX01,  a});
    exp_q.push_back({IO_HEX23,  b});
    exp_q.push_back({IO_HEX45,  s});
    exp_q.push_back({IO_LED_LO, a});
    exp_q.push_back({IO_LED_HI, b});
  endtask

  task automatic compare_writes(string tag);
    logic [9:0] e;
    check({tag, "_nwrites"}, wr_q.size(), exp_q.size());
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (wr_q.size() > 0) check({tag, "_write"}, {22'd0, wr_q.pop_front()}, {22'd0, e});
    end
    wr_q.delete();
  endtask

  task automatic clear_counts();
    rd5_cnt  = 0;
    rd6_cnt  = 0;
    done_cnt = 0;
    wr_q.delete();
    exp_q.delete();
  endtask

  task automatic wait_done(string tag, int budget);
    int k;
    k = 0;
    while (!sweep_done && k < budget) begin
      tick(1);
      k++;
    end
    check({tag, "_sweep_done"}, {31'd0, sweep_done}, 32'd1);
  endtask

  task automatic wait_write(string tag, logic [3:0] addr, int budget);
    int k;
    k = 0;
    while (!(bus.io_we && bus.io_addr == addr) && k < budget) begin
      tick(1);
      k++;
    end
    check({tag, "_write_seen"}, {31'd0, bus.io_we}, 32'd1);
  endtask

  task automatic wait_rda(string tag, int budget);
    int k;
    k = 0;
    while (!(bus.io_addr == IO_SW_LO && !bus.io_we) && k < budget) begin
      tick(1);
      k++;
    end
    check({tag, "_rda_seen"}, {28'd0, bus.io_addr}, {28'd0, IO_SW_LO});
  endtask

  task automatic wait_rda1(string tag, int budget);
    int k;
    k = 0;
    while (!(bus1.io_addr == IO_SW_LO && !bus1.io_we) && k < budget) begin
      tick(1);
      k++;
    end
    check({tag, "_rda_seen"}, {28'd0, bus1.io_addr}, {28'd0, IO_SW_LO});
  endtask

  // ---------------- stimulus ----------------
  logic [5:0] exp_sum1;

  initial begin
    // Reset state.
    resetn = 1'b0;
    tick(3);
    check("rst_we",         {31'd0, bus.io_we},   32'd0);
    check("rst_addr",       {28'd0, bus.io_addr}, 32'd0);
    check("rst_wdata",      bus.io_wdata,         32'd0);
    check("rst_busy",       {31'd0, busy},        32'd0);
    check("rst_sweep_done", {31'd0, sweep_done},  32'd0);
    check("rst_sum_out",    {26'd0, sum_out},     32'd0);
    check("rst_state",      32'(state_dbg),       32'(ST_IDLE));

    // Sweep 1: A=5, B=3 -> full write-back, sum 8.
    clear_counts();
    sw      = {5'd3, 5'd5};
    resetn  = 1'b1;
    enable  = 1'b1;
    enable1 = 1'b1;
    exp_sweep(6'd5, 6'd3, 6'd8);
    wait_done("s1", 40);
    check("s1_busy_in_done", {31'd0, busy}, 32'd1);
    tick(2);
    compare_writes("s1");
    check("s1_rd5",        rd5_cnt, 32'd1);
    check("s1_rd6",        rd6_cnt, 32'd1);
    check("s1_done_once",  done_cnt, 32'd1);
    check("s1_done_low",   {31'd0, sweep_done}, 32'd0);
    check("s1_sum_out",    {26'd0, sum_out}, 32'd8);
    check("s1_latency",    lat, 32'd4);

    // Sweep 2: same switches -> reads only, no writes, no sweep_done.
    clear_counts();
    wait_rda("s2", 40);
    check("s2_period_full", period, 32'(P_MAIN + 10));
    tick(5);
    compare_writes("s2");
    check("s2_rd5",       rd5_cnt, 32'd1);
    check("s2_rd6",       rd6_cnt, 32'd1);
    check("s2_no_done",   done_cnt, 32'd0);
    check("s2_busy_wait", {31'd0, busy}, 32'd0);

    // Sweep 3 follows a skipped sweep: short period.
    wait_rda("s3", 40);
    check("s3_period_skip", period, 32'(P_MAIN + 4));
    tick(5);

    // Sweep 4: A=31, B=31 -> hex45 gets 62.
    clear_counts();
    sw = {5'd31, 5'd31};
    exp_sweep(6'd31, 6'd31, 6'd62);
    wait_done("s4", 40);
    tick(2);
    compare_writes("s4");
    check("s4_hex45_wdata", last_h45, 32'd62);
    check("s4_sum_out",     {26'd0, sum_out}, 32'd62);
    check("s4_done_once",   done_cnt, 32'd1);

    // Sweep 5: drop enable during WR_H1; the sweep finishes then idles.
    clear_counts();
    sw = {5'd20, 5'd10};
    exp_sweep(6'd10, 6'd20, 6'd30);
    wait_write("s5_h1", IO_HEX23, 40);
    enable = 1'b0;
    wait_done("s5", 20);
    tick(2);
    compare_writes("s5");
    check("s5_sum_out",  {26'd0, sum_out}, 32'd30);
    check("s5_done",     done_cnt, 32'd1);
    rd5_cnt = 0;
    tick(20);
    check("s5_no_reads", rd5_cnt, 32'd0);
    check("s5_busy",     {31'd0, busy}, 32'd0);
    check("s5_idle",     32'(state_dbg), 32'(ST_IDLE));

    // Sweep 6: reset during WR_H2 cuts the sequence off.
    clear_counts();
    sw     = {5'd9, 5'd7};
    enable = 1'b1;
    exp_q.push_back({IO_HEX01, 6'd7});
    exp_q.push_back({IO_HEX23, 6'd9});
    exp_q.push_back({IO_HEX45, 6'd16});
    wait_write("s6_h2", IO_HEX45, 40);
    resetn = 1'b0;
    tick(1);
    check("s6_rst_we",    {31'd0, bus.io_we},   32'd0);
    check("s6_rst_addr",  {28'd0, bus.io_addr}, 32'd0);
    check("s6_rst_wdata", bus.io_wdata,         32'd0);
    check("s6_rst_busy",  {31'd0, busy},        32'd0);
    check("s6_rst_sum",   {26'd0, sum_out},     32'd0);
    check("s6_rst_state", 32'(state_dbg),       32'(ST_IDLE));
    compare_writes("s6_partial");

    // After reset, switches equal to the cleared last values still write.
    clear_counts();
    sw     = '0;
    resetn = 1'b1;
    exp_sweep(6'd0, 6'd0, 6'd0);
    wait_done("s7", 40);
    tick(2);
    compare_writes("s7");
    check("s7_done", done_cnt, 32'd1);

    // POLL_PERIOD=1 instance: switches flipping every sweep, then steady.
    wait_rda1("f1", 40);
    check("f1_period_full", period1, 32'(P_FAST + 10));
    wait_rda1("f2", 40);
    check("f2_period_full", period1, 32'(P_FAST + 10));
    toggle1 = 1'b0;
    tick(1);
    wait_rda1("f3", 40);
    check("f3_period_full", period1, 32'(P_FAST + 10));
    done1_cnt = 0;
    tick(1);
    wait_rda1("f4", 40);
    check("f4_period_skip", period1, 32'(P_FAST + 4));
    check("f4_no_done",     done1_cnt, 32'd0);
    exp_sum1 = {1'b0, sw1[4:0]} + {1'b0, sw1[9:5]};
    check("f4_sum_out",     {26'd0, sum_out1}, {26'd0, exp_sum1});
    enable1 = 1'b0;
    tick(12);
    check("f5_idle",        32'(state_dbg1), 32'(ST_IDLE));
    check("f5_busy",        {31'd0, busy1}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
